// File: rtl/instruction_pkg.sv
// Decoded instruction type and RV32 base opcode constants.
package instruction_pkg;
  import typedef_pkg::*;

  localparam logic [6:0] OP_LUI    = 7'h37;
  localparam logic [6:0] OP_AUIPC  = 7'h17;
  localparam logic [6:0] OP_JAL    = 7'h6f;
  localparam logic [6:0] OP_JALR   = 7'h67;
  localparam logic [6:0] OP_BRANCH = 7'h63;
  localparam logic [6:0] OP_LOAD   = 7'h03;
  localparam logic [6:0] OP_STORE  = 7'h23;
  localparam logic [6:0] OP_IMM    = 7'h13;
  localparam logic [6:0] OP_REG    = 7'h33;

  typedef struct packed {
    logic [XLEN-1:0] addr;
    logic [6:0]      opcode;
    logic [4:0]      rd_addr;
    logic [4:0]      rs1_addr;
    logic [4:0]      rs2_addr;
    logic [2:0]      funct3;
    logic [6:0]      funct7;
    logic [31:0]     immediate;
    logic            valid;
  } instruction_t;
endpackage

// File: rtl/typedef_pkg.sv
// Shared fetch-side types.
package typedef_pkg;
  localparam int XLEN = 32;
  localparam int ILEN = 32;

  typedef struct packed {
    logic [XLEN-1:0] addr;
    logic [ILEN-1:0] data;
    logic            valid;
  } fetch_t;
endpackage

// File: rtl/InstructionDecode.sv
// Purely combinational RV32 field extraction and immediate generation.
module InstructionDecode
  import typedef_pkg::*;
  import instruction_pkg::*;
(
  input  fetch_t       fetch,
  output instruction_t instr
);

  logic [31:0] d;
  assign d = fetch.data;

  // Fixed-position fields plus format-dependent immediate; unknown opcodes get imm 0.
  always_comb begin
    instr           = '0;
    instr.addr      = fetch.addr;
    instr.valid     = fetch.valid;
    instr.opcode    = d[6:0];
    instr.rd_addr   = d[11:7];
    instr.funct3    = d[14:12];
    instr.rs1_addr  = d[19:15];
    instr.rs2_addr  = d[24:20];
    instr.funct7    = d[31:25];
    case (d[6:0])
      OP_IMM, OP_LOAD, OP_JALR: instr.immediate = {{20{d[31]}}, d[31:20]};
      OP_STORE:                 instr.immediate = {{20{d[31]}}, d[31:25], d[11:7]};
      OP_BRANCH:                instr.immediate = {{19{d[31]}}, d[31], d[7], d[30:25], d[11:8], 1'b0};
      OP_LUI, OP_AUIPC:         instr.immediate = {d[31:12], 12'b0};
      OP_JAL:                   instr.immediate = {{11{d[31]}}, d[31], d[19:12], d[20], d[30:21], 1'b0};
      default:                  instr.immediate = '0;
    endcase
  end

endmodule

// File: rtl/decode_queue_ctrl.sv
// Fetch buffer FIFO feeding a registered decode stage toward rename.
module decode_queue_ctrl
  import typedef_pkg::*;
  import instruction_pkg::*;
#(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int DEPTH      = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     fetch_valid,
  output logic                     fetch_ready,
  input  fetch_t                   fetch_instr,
  input  logic                     flush,
  output logic                     out_valid,
  input  logic                     out_ready,
  output instruction_t             out_instr,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [PW-1:0]         wr_ptr, rd_ptr;
  logic [ADDR_WIDTH-1:0] mem_addr [DEPTH];
  logic [DATA_WIDTH-1:0] mem_data [DEPTH];
  logic [DEPTH-1:0]      mem_vld;

  logic         push, pop, advance, not_empty;
  fetch_t       head;
  instruction_t dec_instr;

  // Full is judged from occupancy alone so fetch never waits on rename combinationally.
  assign fetch_ready = (count != CW'(DEPTH));
  assign not_empty   = (count != '0);
  assign advance     = !out_valid || out_ready;
  assign push        = fetch_valid && fetch_ready && !flush;
  assign pop         = advance && not_empty && !flush;

  // Storage is left unreset; entries are only observed while count != 0.
  always_ff @(posedge clk) begin
    if (push) begin
      mem_addr[wr_ptr] <= ADDR_WIDTH'(fetch_instr.addr);
      mem_data[wr_ptr] <= DATA_WIDTH'(fetch_instr.data);
      mem_vld[wr_ptr]  <= fetch_instr.valid;
    end
  end

  // Reassemble the head entry for the decoder.
  always_comb begin
    head       = '0;
    head.addr  = XLEN'(mem_addr[rd_ptr]);
    head.data  = ILEN'(mem_data[rd_ptr]);
    head.valid = mem_vld[rd_ptr];
  end

  InstructionDecode u_decode (
    .fetch (head),
    .instr (dec_instr)
  );

  // Pointer/occupancy bookkeeping and the output register; flush wins over any push/pop.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= '0;
      out_valid <= 1'b0;
      out_instr <= '0;
    end else if (flush) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= '0;
      out_valid <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      if (push && !pop)      count <= count + 1'b1;
      else if (!push && pop) count <= count - 1'b1;
      if (advance) begin
        out_valid <= pop;
        if (pop) out_instr <= dec_instr;
      end
    end
  end

endmodule

// File: tb/tb_decode_queue_ctrl.sv
// Scoreboarded bench for decode_queue_ctrl: monitor compares every rename handshake.
module tb_decode_queue_ctrl;
  import typedef_pkg::*;
  import instruction_pkg::*;

  localparam int DEPTH = 4;

  logic         clk = 1'b0;
  logic         rst;
  logic         fetch_valid;
  logic         fetch_ready;
  fetch_t       fetch_instr;
  logic         flush;
  logic         out_valid;
  logic         out_ready;
  instruction_t out_instr;
  logic [2:0]   count;

  int tests_run = 0;
  int failed    = 0;
  fetch_t exp_q[$];

  decode_queue_ctrl #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .DEPTH(DEPTH)) dut (
    .clk         (clk),
    .rst         (rst),
    .fetch_valid (fetch_valid),
    .fetch_ready (fetch_ready),
    .fetch_instr (fetch_instr),
    .flush       (flush),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_instr   (out_instr),
    .count       (count)
  );

  always #5 clk = ~clk;

  // addi x1, x0, i
  function automatic logic [31:0] mkword(int i);
    return {12'(i), 5'd0, 3'd0, 5'd1, 7'h13};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(logic v, logic [31:0] a, logic [31:0] d);
    fetch_valid       = v;
    fetch_instr.addr  = a;
    fetch_instr.data  = d;
    fetch_instr.valid = 1'b1;
  endtask

  // Scoreboard: inputs are stable from posedge+1 until the next posedge, so the
  // negedge view predicts exactly what the coming edge will accept.
  always @(negedge clk) begin
    fetch_t e;
    logic [31:0] exp_imm;
    if (rst) begin
      exp_q.delete();
    end else begin
      if (out_valid && out_ready) begin
        tests_run++;
        if (exp_q.size() == 0) begin
          failed++;
          $display("FAIL sb_unexpected_output got addr=%h with nothing expected", out_instr.addr);
        end else begin
          e = exp_q.pop_front();
          exp_imm = {{20{e.data[31]}}, e.data[31:20]};
          if (out_instr.addr !== e.addr || out_instr.opcode !== e.data[6:0] ||
              out_instr.immediate !== exp_imm || out_instr.valid !== e.valid) begin
            failed++;
            $display("FAIL sb_order got addr=%h op=%h imm=%h v=%b required addr=%h op=%h imm=%h v=%b",
                     out_instr.addr, out_instr.opcode, out_instr.immediate, out_instr.valid,
                     e.addr, e.data[6:0], exp_imm, e.valid);
          end
        end
      end
      if (flush) exp_q.delete();
      else if (fetch_valid && fetch_ready) exp_q.push_back(fetch_instr);
    end
  end

  task automatic test_reset();
    tick();
    tests_run++;
    if (count !== 3'd0 || out_valid !== 1'b0 || fetch_ready !== 1'b1 || out_instr !== '0) begin
      failed++;
      $display("FAIL reset_state got count=%0d ov=%b fr=%b instr=%h required 0 0 1 0",
               count, out_valid, fetch_ready, out_instr);
    end
    rst = 1'b0;
    tick();
  endtask

  task automatic test_single();
    out_ready = 1'b1;
    drive(1'b1, 32'h100, 32'h00500093);
    tick();
    drive(1'b0, 32'h0, 32'h0);
    tests_run++;
    if (out_valid !== 1'b0) begin
      failed++;
      $display("FAIL single_no_bypass got out_valid=%b required 0", out_valid);
    end
    tick();
    tests_run++;
    if (out_valid !== 1'b1 || out_instr.opcode !== 7'h13 || out_instr.rd_addr !== 5'd1 ||
        out_instr.rs1_addr !== 5'd0 || out_instr.funct3 !== 3'd0 ||
        out_instr.immediate !== 32'd5 || out_instr.addr !== 32'h100) begin
      failed++;
      $display("FAIL single_decode got ov=%b op=%h rd=%0d rs1=%0d f3=%0d imm=%h addr=%h required 1 13 1 0 0 5 100",
               out_valid, out_instr.opcode, out_instr.rd_addr, out_instr.rs1_addr,
               out_instr.funct3, out_instr.immediate, out_instr.addr);
    end
    tick();
  endtask

  task automatic test_fill();
    out_ready = 1'b0;
    for (int i = 0; i < 6; i++) begin
      drive(1'b1, 32'(i * 4), mkword(i + 1));
      if (i == 5) begin
        tests_run++;
        if (fetch_ready !== 1'b0) begin
          failed++;
          $display("FAIL fill_backpressure got fetch_ready=%b required 0", fetch_ready);
        end
      end
      tick();
    end
    drive(1'b0, 32'h0, 32'h0);
    tests_run++;
    if (count !== 3'd4 || out_valid !== 1'b1 || out_instr.addr !== 32'h0) begin
      failed++;
      $display("FAIL fill_state got count=%0d ov=%b addr=%h required 4 1 0",
               count, out_valid, out_instr.addr);
    end
    out_ready = 1'b1;
    for (int i = 0; i < 6; i++) tick();
    tests_run++;
    if (count !== 3'd0 || out_valid !== 1'b0 || exp_q.size() != 0) begin
      failed++;
      $display("FAIL fill_drain got count=%0d ov=%b pending=%0d required 0 0 0",
               count, out_valid, exp_q.size());
    end
  endtask

  task automatic test_streaming();
    out_ready = 1'b1;
    for (int i = 0; i < 12; i++) begin
      drive(1'b1, 32'h1000 + 32'(i * 4), mkword(i + 20));
      tick();
      tests_run++;
      if (count > 3'd1 || (i >= 1 && out_valid !== 1'b1)) begin
        failed++;
        $display("FAIL stream_cycle%0d got count=%0d ov=%b required count<=1 ov=1", i, count, out_valid);
      end
    end
    drive(1'b0, 32'h0, 32'h0);
    tick();
    tick();
    tests_run++;
    if (exp_q.size() != 0 || out_valid !== 1'b0) begin
      failed++;
      $display("FAIL stream_drain got pending=%0d ov=%b required 0 0", exp_q.size(), out_valid);
    end
  endtask

  task automatic test_flush();
    out_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, 32'h300 + 32'(i * 4), mkword(i + 40));
      tick();
    end
    tests_run++;
    if (count !== 3'd3 || out_valid !== 1'b1) begin
      failed++;
      $display("FAIL flush_setup got count=%0d ov=%b required 3 1", count, out_valid);
    end
    flush = 1'b1;
    drive(1'b1, 32'hDEAD0, mkword(99));
    tick();
    flush = 1'b0;
    drive(1'b0, 32'h0, 32'h0);
    tests_run++;
    if (count !== 3'd0 || out_valid !== 1'b0 || fetch_ready !== 1'b1) begin
      failed++;
      $display("FAIL flush_state got count=%0d ov=%b fr=%b required 0 0 1", count, out_valid, fetch_ready);
    end
    out_ready = 1'b1;
    drive(1'b1, 32'h200, mkword(7));
    tick();
    drive(1'b0, 32'h0, 32'h0);
    tick();
    tests_run++;
    if (out_valid !== 1'b1 || out_instr.addr !== 32'h200) begin
      failed++;
      $display("FAIL flush_recover got ov=%b addr=%h required 1 200", out_valid, out_instr.addr);
    end
    tick();
  endtask

  task automatic test_push_pop();
    out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 32'h400 + 32'(i * 4), mkword(i + 60));
      tick();
    end
    tests_run++;
    if (count !== 3'd2 || out_valid !== 1'b1) begin
      failed++;
      $display("FAIL pushpop_setup got count=%0d ov=%b required 2 1", count, out_valid);
    end
    out_ready = 1'b1;
    drive(1'b1, 32'h40C, mkword(63));
    tick();
    drive(1'b0, 32'h0, 32'h0);
    tests_run++;
    if (count !== 3'd2 || out_instr.addr !== 32'h404) begin
      failed++;
      $display("FAIL pushpop_count got count=%0d addr=%h required 2 404", count, out_instr.addr);
    end
    for (int i = 0; i < 4; i++) tick();
    tests_run++;
    if (exp_q.size() != 0 || out_valid !== 1'b0) begin
      failed++;
      $display("FAIL pushpop_drain got pending=%0d ov=%b required 0 0", exp_q.size(), out_valid);
    end
  endtask

  task automatic test_reset_mid();
    out_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, 32'h500 + 32'(i * 4), mkword(i + 80));
      tick();
    end
    drive(1'b0, 32'h0, 32'h0);
    #2 rst = 1'b1;
    #1;
    tests_run++;
    if (count !== 3'd0 || out_valid !== 1'b0 || fetch_ready !== 1'b1 || out_instr !== '0) begin
      failed++;
      $display("FAIL reset_async got count=%0d ov=%b fr=%b instr=%h required 0 0 1 0",
               count, out_valid, fetch_ready, out_instr);
    end
    tick();
    rst = 1'b0;
    out_ready = 1'b1;
    tick();
    tick();
    tests_run++;
    if (out_instr !== '0 || out_valid !== 1'b0 || count !== 3'd0) begin
      failed++;
      $display("FAIL reset_hold got instr=%h ov=%b count=%0d required 0 0 0", out_instr, out_valid, count);
    end
  endtask

  initial begin
    rst         = 1'b1;
    flush       = 1'b0;
    out_ready   = 1'b0;
    fetch_valid = 1'b0;
    fetch_instr = '0;
    test_reset();
    test_single();
    test_fill();
    test_streaming();
    test_flush();
    test_push_pop();
    test_reset_mid();
    tests_run++;
    if (exp_q.size() != 0) begin
      failed++;
      $display("FAIL sb_leftover got pending=%0d required 0", exp_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests_run, failed);
    $finish;
  end

endmodule

// File: doc/decode_queue_ctrl.md
# decode_queue_ctrl

Decode-stage controller between instruction fetch and rename. It buffers fetched words in a small FIFO and sequences them one per cycle through the `InstructionDecode` datapath. It presents the decoded instruction to rename through a registered valid/ready handshake. It also handles pipeline flush on redirect.

## Interface
Parameters:
- `ADDR_WIDTH`, default 32: PC width, matching `fetch_t.addr`.
- `DATA_WIDTH`, default 32: instruction word width, matching `fetch_t.data`.
- `DEPTH`, default 4: FIFO entries. Must be a power of 2 and at least 2.

Ports (one clock; reset is asynchronous and active-high):
- `clk`  in  1  system clock, rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `fetch_valid`  in  1  fetch presents a word.
- `fetch_ready`  out  1  the queue can accept a word this cycle.
- `fetch_instr`  in  `fetch_t`  fetched word, carrying addr, data and valid.
- `flush`  in  1  redirect: discard all buffered and in-flight instructions.
- `out_valid`  out  1  `out_instr` holds a decoded instruction.
- `out_ready`  in  1  rename accepts `out_instr` this cycle.
- `out_instr`  out  `instruction_t`  registered decoded instruction.
- `count`  out  `$clog2(DEPTH)+1`  current FIFO occupancy.

## Operation
- **Push:** occurs when `fetch_valid && fetch_ready && !flush`. The word is written at `wr_ptr`, then `wr_ptr` increments.
  - `fetch_ready = (count != DEPTH)`. It is combinational from state only, with no dependence on `out_ready`.
- **Head decode:** the FIFO head entry drives the `InstructionDecode` instance combinationally.
- **Advance:** `advance = (!out_valid || out_ready)`.
  - If `advance` is true and `count != 0`: `out_instr` loads the decoder output, `out_valid` is set to 1, and the head is popped (`rd_ptr` increments).
  - If `advance` is true and `count == 0`: `out_valid` is cleared to 0.
  - If `advance` is false: `out_instr` and `out_valid` hold.
- **Loaded valid field:** `out_instr.valid` is loaded from the stored `fetch_t.valid`, not forced to 1.
- **Push and pop in the same cycle:** `count` is unchanged and both pointers advance.
- **Pointers:** `wr_ptr` and `rd_ptr` are `$clog2(DEPTH)` bits. They wrap modulo DEPTH naturally; `count` distinguishes full from empty.
- **Flush:** in the cycle `flush` is high, the registered updates are forced as follows:
  - `wr_ptr`, `rd_ptr` and `count` go to 0 and `out_valid` goes to 0.
  - A simultaneous push is dropped and a simultaneous pop is ignored.
  - A handshake with `out_ready` in the same cycle is treated as accepted by rename; rename squashes it itself.
- **Reset:** `rst` asserted at any time immediately clears pointers, `count`, `out_valid` and `out_instr` to 0. This includes reset in the middle of a burst.
- **Storage:** FIFO storage entries are not reset. They are only read when `count != 0`.

## Timing
- **Minimum latency:** word pushed at edge N, queue empty and `out_ready` high. Then `out_valid` is 1 with the decoded word after edge N+1. This is one cycle of FIFO plus a registered decode.
- **No bypass:** there is no path from fetch straight to the output.
- **Throughput:** one instruction per cycle when `fetch_valid` and `out_ready` are held high.
- **Stall:** when `out_ready` is low with `out_valid` high, `out_instr` is held stable.
- **Backpressure:** fetch is backpressured only when DEPTH entries are buffered. Total capacity is DEPTH+1, including the output register.
- **Reset values of outputs:**
  - `fetch_ready = 1`
  - `out_valid = 0`
  - `out_instr = '0`
  - `count = 0`
- **Flush recovery:** after a flush, `fetch_ready = 1` in the next cycle. A push in that next cycle produces `out_valid` one cycle later.

## Structure
- `fetch_t`, `instruction_t` and the opcode constants stay in `typedef_pkg` / `instruction_pkg`. Nothing new is added to the packages.
- One sub-module: `InstructionDecode` (instance `u_decode`), fed by the FIFO head.
- Local to this block: FIFO storage array, two pointers, occupancy counter, output register.

## Test plan
- **Reset:** assert `rst` mid-stream with 3 entries buffered and `out_valid=1`.
  - Required: immediately `count=0`, `out_valid=0`, `fetch_ready=1`.
  - Required: `out_instr` all zero until the next decode.
- **Single decode:** push addr 0x100, data 0x00500093 (addi x1,x0,5) with `out_ready=1`.
  - Required: one cycle later `out_valid=1`, opcode 0x13, `rd_addr=1`, `rs1_addr=0`, funct3 0, immediate 5, addr 0x100.
- **Fill and backpressure:** hold `out_ready=0` and push 6 words at addr 0x0, 0x4, …
  - Required: the first goes to the output register, then `count` reaches 4, then `fetch_ready=0`; the 6th word is not accepted.
  - Then raise `out_ready`. Required: outputs appear in order 0x0, 0x4, 0x8, 0xC, 0x10.
- **Streaming:** push continuously with `out_ready=1`.
  - Required: `count` stays at 0 or 1, and one output per cycle after the first.
  - Required: pointers wrap past DEPTH with addresses strictly in order.
- **Flush:** 3 entries buffered, `out_valid=1`, `flush` and `fetch_valid` high in the same cycle.
  - Required next cycle: `count=0`, `out_valid=0`, and the flushed-cycle word never appears.
  - Then push addr 0x200. Required: it is the next output.
- **Simultaneous push/pop:** with `count=2`, push and pop in the same cycle.
  - Required: `count` stays 2 and order is preserved.
